// File: rtl/waveform_buffer_reader_if.sv
// Signal bundle between the waveform buffer reader and its surroundings:
// frame control, the RAM read port and the column stream to the plotter.
interface waveform_buffer_reader_if;
  logic        frame_start;
  logic [9:0]  wr_ptr;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic        col_valid;
  logic        col_ready;
  logic [9:0]  col_x;
  logic [8:0]  col_y;
  logic        busy;
  logic        frame_done;

  // Environment side: drives frame control, RAM data and plotter ready.
  modport master (
    output frame_start, wr_ptr, ram_data, col_ready,
    input  ram_addr, col_valid, col_x, col_y, busy, frame_done
  );

  // Reader side.
  modport slave (
    input  frame_start, wr_ptr, ram_data, col_ready,
    output ram_addr, col_valid, col_x, col_y, busy, frame_done
  );
endinterface

// File: rtl/waveform_buffer_reader.sv
// Waveform buffer reader: walks the circular sample buffer once per frame,
// starting at the oldest sample, converts each 12-bit sample to a screen row
// and streams one column per sample to the plotter through a small skid FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for frame_start (ignored in the frame_done cycle)
// FETCH | issuing RAM reads while a FIFO slot can be reserved for the data
// DRAIN | all reads issued; waiting for the plotter to take the last column
module waveform_buffer_reader #(
  parameter logic [11:0] BASE_ADDR  = 12'h801,
  parameter int          DEPTH      = 640,
  parameter int          Y_MAX      = 479,
  parameter int          FIFO_DEPTH = 4
) (
  input logic                     clock,
  input logic                     reset,
  waveform_buffer_reader_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [9:0]    rd_idx;
  logic [9:0]    read_cnt;
  logic [9:0]    col_x_q;
  logic          inflight;
  logic          frame_done_q;

  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] fifo_wp;
  logic [PW-1:0] fifo_rp;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;

  logic          start;
  logic          issue;
  logic          busy_w;
  logic [11:0]   ram_addr_w;
  logic          col_valid_w;
  logic          push;
  logic          pop;
  logic          last_read;
  logic          last_pop;
  logic [8:0]    sample_t;
  logic [8:0]    sample_y;
  logic          unused_data;

  // Reads in flight count against FIFO space so returning data always has a slot.
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign col_valid_w = (fifo_count != '0);
  assign push        = inflight;
  assign pop         = col_valid_w & bus.col_ready;
  assign last_read   = (read_cnt == 10'(DEPTH - 1));
  assign last_pop    = pop && (state == DRAIN) && (col_x_q == 10'(DEPTH - 1));

  // Row = Y_MAX - min(sample >> 3, Y_MAX); only the low 12 bits carry the sample.
  assign sample_t    = bus.ram_data[11:3];
  assign sample_y    = (sample_t > 9'(Y_MAX)) ? 9'd0 : 9'(Y_MAX) - sample_t;
  assign unused_data = ^{bus.ram_data[31:12], bus.ram_data[2:0]};

  assign bus.ram_addr   = ram_addr_w;
  assign bus.busy       = busy_w;
  assign bus.col_valid  = col_valid_w;
  assign bus.col_x      = col_x_q;
  assign bus.col_y      = fifo_mem[fifo_rp];
  assign bus.frame_done = frame_done_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)               state_nxt = FETCH;
      FETCH:   if (issue && last_read)  state_nxt = DRAIN;
      DRAIN:   if (last_pop)            state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // FSM outputs: frame acceptance, read issue, busy and the RAM address.
  always_comb begin
    start      = (state == IDLE) && bus.frame_start && !frame_done_q;
    issue      = (state == FETCH) && (occupancy < (CW+1)'(FIFO_DEPTH));
    busy_w     = (state != IDLE);
    ram_addr_w = BASE_ADDR + {2'b00, rd_idx};
  end

  // Read index/count, in-flight flag, column counter and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_idx       <= '0;
      read_cnt     <= '0;
      inflight     <= 1'b0;
      col_x_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_pop;
      if (start) begin
        rd_idx   <= (bus.wr_ptr >= 10'(DEPTH)) ? 10'd0 : bus.wr_ptr;
        read_cnt <= '0;
        inflight <= 1'b0;
        col_x_q  <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          read_cnt <= read_cnt + 10'd1;
          // The final read leaves rd_idx alone so ram_addr holds through DRAIN.
          if (!last_read)
            rd_idx <= (rd_idx == 10'(DEPTH - 1)) ? 10'd0 : rd_idx + 10'd1;
        end
        if (pop)
          col_x_q <= (col_x_q == 10'(DEPTH - 1)) ? 10'd0 : col_x_q + 10'd1;
      end
    end
  end

  // Skid FIFO: push returning read data (already converted), pop on handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_wp    <= '0;
      fifo_rp    <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (start) begin
      fifo_wp    <= '0;
      fifo_rp    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= sample_y;
        fifo_wp <= (fifo_wp == PW'(FIFO_DEPTH - 1)) ? '0 : fifo_wp + 1'b1;
      end
      if (pop)
        fifo_rp <= (fifo_rp == PW'(FIFO_DEPTH - 1)) ? '0 : fifo_rp + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
